// File: rtl/reg_trace_monitor.sv
// Passive monitor for the reg_req/reg_rsp bus: tracks each transaction, logs completed
// ones into a circular trace buffer, and keeps counters, a stall watchdog and protocol flags.
module reg_trace_monitor #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int DEPTH          = 16,
    parameter int LAT_WIDTH      = 16,
    parameter int TIMEOUT_CYCLES = 256,
    parameter bit OVERWRITE      = 1'b1,
    localparam int STRB_W        = DATA_WIDTH / 8,
    localparam int ENTRY_W       = 3 + STRB_W + ADDR_WIDTH + DATA_WIDTH + LAT_WIDTH,
    localparam int CNT_W         = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  clear,
    input  logic                  req_valid,
    input  logic                  req_write,
    input  logic [STRB_W-1:0]     req_wstrb,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic                  rsp_ready,
    input  logic                  rsp_error,
    input  logic [DATA_WIDTH-1:0] rsp_rdata,
    input  logic                  trace_pop,
    output logic                  trace_valid,
    output logic [ENTRY_W-1:0]    trace_entry,
    output logic [CNT_W-1:0]      trace_count,
    output logic                  overflow,
    output logic                  timeout,
    output logic                  proto_err,
    output logic [31:0]           rd_count,
    output logic [31:0]           wr_count,
    output logic [31:0]           err_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int TW    = $clog2(TIMEOUT_CYCLES + 1);
    // Wait counter must reach TIMEOUT_CYCLES even when the latency field is narrower.
    localparam int LC_W  = (TW > LAT_WIDTH) ? TW : LAT_WIDTH;
    localparam logic [LC_W-1:0]  TMO_VAL  = LC_W'(TIMEOUT_CYCLES);
    localparam logic [LC_W-1:0]  LAT_MAX  = LC_W'({LAT_WIDTH{1'b1}});
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [31:0]      CNT_MAX  = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_STALL = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [LC_W-1:0]         lat_q, lat_d, lat_inc_s;
    logic                    cap_write_q;
    logic [STRB_W-1:0]       cap_wstrb_q;
    logic [ADDR_WIDTH-1:0]   cap_addr_q;
    logic [DATA_WIDTH-1:0]   cap_wdata_q;
    logic                    cap_en_s, push_s, proto_set_s, tmo_set_s;
    logic [ENTRY_W-1:0]      push_entry_s;
    logic                    field_chg_s, complete_s, cnt_write_s;
    logic [ENTRY_W-1:0]      mem_q [DEPTH];
    logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]        count_q;
    logic                    full_s, pop_s, wr_en_s, rd_adv_s, ovf_set_s;
    logic                    ovf_q, tmo_q, proto_q;
    logic [31:0]             rd_cnt_q, wr_cnt_q, err_cnt_q;

    function automatic logic [LAT_WIDTH-1:0] lat_field(input logic [LC_W-1:0] v);
        return (v > LAT_MAX) ? {LAT_WIDTH{1'b1}} : v[LAT_WIDTH-1:0];
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic inc);
        return (inc && (v != CNT_MAX)) ? (v + 32'd1) : v;
    endfunction

    function automatic logic [ENTRY_W-1:0] pack_entry(
        input logic tmo, input logic err, input logic wr,
        input logic [STRB_W-1:0] s, input logic [ADDR_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] d, input logic [LAT_WIDTH-1:0] l);
        return {tmo, err, wr, s, a, d, l};
    endfunction

    assign lat_inc_s    = lat_q + LC_W'(1);
    assign field_chg_s  = (req_write != cap_write_q) || (req_wstrb != cap_wstrb_q) ||
                          (req_addr != cap_addr_q) || (req_wdata != cap_wdata_q);
    assign complete_s   = enable && req_valid && rsp_ready;
    assign cnt_write_s  = (state_q == ST_IDLE) ? req_write : cap_write_q;

    // FSM state, wait counter and captured request fields
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            lat_q       <= '0;
            cap_write_q <= 1'b0;
            cap_wstrb_q <= '0;
            cap_addr_q  <= '0;
            cap_wdata_q <= '0;
        end else if (clear) begin
            state_q <= ST_IDLE;
            lat_q   <= '0;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
            if (cap_en_s) begin
                cap_write_q <= req_write;
                cap_wstrb_q <= req_wstrb;
                cap_addr_q  <= req_addr;
                cap_wdata_q <= req_wdata;
            end
        end
    end

    // Next-state logic; a disabled monitor always sits in IDLE
    always_comb begin
        state_d = state_q;
        if (!enable) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:  state_d = (req_valid && !rsp_ready) ? ST_WAIT : ST_IDLE;
                ST_WAIT: begin
                    if (!req_valid || rsp_ready) begin
                        state_d = ST_IDLE;
                    end else if (lat_inc_s == TMO_VAL) begin
                        state_d = ST_STALL;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
                ST_STALL: state_d = (!req_valid || rsp_ready) ? ST_IDLE : ST_STALL;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // Per-state actions: logging, capture, latency tracking and flag events
    always_comb begin
        push_s       = 1'b0;
        push_entry_s = '0;
        proto_set_s  = 1'b0;
        tmo_set_s    = 1'b0;
        cap_en_s     = 1'b0;
        lat_d        = '0;
        if (enable) begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid && rsp_ready) begin
                        push_s       = 1'b1;
                        push_entry_s = pack_entry(1'b0, rsp_error, req_write, req_wstrb, req_addr,
                                                  req_write ? req_wdata : rsp_rdata, '0);
                    end else if (req_valid) begin
                        cap_en_s = 1'b1;
                        lat_d    = LC_W'(1);
                    end else begin
                        lat_d = '0;
                    end
                end
                ST_WAIT: begin
                    if (!req_valid) begin
                        proto_set_s = 1'b1;
                    end else if (rsp_ready) begin
                        push_s       = 1'b1;
                        push_entry_s = pack_entry(1'b0, rsp_error, cap_write_q, cap_wstrb_q, cap_addr_q,
                                                  cap_write_q ? cap_wdata_q : rsp_rdata, lat_field(lat_q));
                    end else begin
                        proto_set_s = field_chg_s;
                        lat_d       = lat_inc_s;
                        if (lat_inc_s == TMO_VAL) begin
                            push_s       = 1'b1;
                            tmo_set_s    = 1'b1;
                            push_entry_s = pack_entry(1'b1, 1'b0, cap_write_q, cap_wstrb_q, cap_addr_q,
                                                      '0, lat_field(lat_inc_s));
                        end else begin
                            tmo_set_s = 1'b0;
                        end
                    end
                end
                ST_STALL: begin
                    if (!req_valid) begin
                        proto_set_s = 1'b1;
                    end else if (!rsp_ready) begin
                        lat_d = lat_q;
                    end else begin
                        lat_d = '0;
                    end
                end
                default: lat_d = '0;
            endcase
        end else begin
            lat_d = '0;
        end
    end

    assign full_s    = (count_q == FULL_CNT);
    assign pop_s     = trace_pop && (count_q != '0);
    // A full buffer with no pop either overwrites the oldest entry or rejects the new one.
    assign wr_en_s   = push_s && (!full_s || pop_s || OVERWRITE);
    assign rd_adv_s  = pop_s || (push_s && full_s && OVERWRITE);
    assign ovf_set_s = push_s && full_s && !pop_s;

    // Trace storage
    always_ff @(posedge clk) begin
        if (wr_en_s && !clear) begin
            mem_q[wr_ptr_q] <= push_entry_s;
        end
    end

    // Buffer pointers and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en_s) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (rd_adv_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (push_s && !pop_s && !full_s) begin
                count_q <= count_q + CNT_W'(1);
            end else if (pop_s && !push_s) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

    // Completion counters and sticky flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_cnt_q  <= '0;
            wr_cnt_q  <= '0;
            err_cnt_q <= '0;
            ovf_q     <= 1'b0;
            tmo_q     <= 1'b0;
            proto_q   <= 1'b0;
        end else if (clear) begin
            rd_cnt_q  <= '0;
            wr_cnt_q  <= '0;
            err_cnt_q <= '0;
            ovf_q     <= 1'b0;
            tmo_q     <= 1'b0;
            proto_q   <= 1'b0;
        end else begin
            rd_cnt_q  <= sat_inc(rd_cnt_q, complete_s && !cnt_write_s);
            wr_cnt_q  <= sat_inc(wr_cnt_q, complete_s && cnt_write_s);
            err_cnt_q <= sat_inc(err_cnt_q, complete_s && rsp_error);
            ovf_q     <= ovf_q | ovf_set_s;
            tmo_q     <= tmo_q | tmo_set_s;
            proto_q   <= proto_q | proto_set_s;
        end
    end

    assign trace_valid = (count_q != '0);
    assign trace_entry = trace_valid ? mem_q[rd_ptr_q] : '0;
    assign trace_count = count_q;
    assign overflow    = ovf_q;
    assign timeout     = tmo_q;
    assign proto_err   = proto_q;
    assign rd_count    = rd_cnt_q;
    assign wr_count    = wr_cnt_q;
    assign err_count   = err_cnt_q;

endmodule

// File: tb/tb_reg_trace_monitor.sv
// Scoreboard bench for reg_trace_monitor: a transaction-level model predicts trace entries,
// counters and flags; a monitor compares each popped trace entry against the expected queue.
module tb_reg_trace_monitor;

    localparam int DEPTH   = 16;
    localparam int TMO     = 256;
    localparam bit OVW     = 1'b1;
    localparam int ENTRY_W = 87;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               enable = 1'b0;
    logic               clear = 1'b0;
    logic               req_valid = 1'b0;
    logic               req_write = 1'b0;
    logic [3:0]         req_wstrb = 4'h0;
    logic [31:0]        req_addr = 32'h0;
    logic [31:0]        req_wdata = 32'h0;
    logic               rsp_ready = 1'b0;
    logic               rsp_error = 1'b0;
    logic [31:0]        rsp_rdata = 32'h0;
    logic               trace_pop = 1'b0;
    logic               trace_valid;
    logic [ENTRY_W-1:0] trace_entry;
    logic [4:0]         trace_count;
    logic               overflow, timeout, proto_err;
    logic [31:0]        rd_count, wr_count, err_count;

    reg_trace_monitor dut (
        .clk(clk), .rst(rst), .enable(enable), .clear(clear),
        .req_valid(req_valid), .req_write(req_write), .req_wstrb(req_wstrb),
        .req_addr(req_addr), .req_wdata(req_wdata), .rsp_ready(rsp_ready),
        .rsp_error(rsp_error), .rsp_rdata(rsp_rdata), .trace_pop(trace_pop),
        .trace_valid(trace_valid), .trace_entry(trace_entry), .trace_count(trace_count),
        .overflow(overflow), .timeout(timeout), .proto_err(proto_err),
        .rd_count(rd_count), .wr_count(wr_count), .err_count(err_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [ENTRY_W-1:0] exp_q [$];
    int m_rd, m_wr, m_err;
    bit m_ovf, m_tmo, m_proto, m_en;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [ENTRY_W-1:0] mk(input bit t, input bit e, input bit w,
        input logic [3:0] s, input logic [31:0] a, input logic [31:0] d, input int lat);
        logic [15:0] l;
        l = 16'(lat);
        return {t, e, w, s, a, d, l};
    endfunction

    task automatic model_clear();
        exp_q.delete();
        m_rd = 0; m_wr = 0; m_err = 0;
        m_ovf = 0; m_tmo = 0; m_proto = 0;
    endtask

    task automatic mpush(input logic [ENTRY_W-1:0] e);
        if (exp_q.size() == DEPTH) begin
            m_ovf = 1;
            if (OVW) begin
                void'(exp_q.pop_front());
                exp_q.push_back(e);
            end
        end else begin
            exp_q.push_back(e);
        end
    endtask

    // Monitor: every entry the DUT hands out on a pop must match the model's oldest entry
    always @(negedge clk) begin
        if (!rst && trace_pop && trace_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL entry_extra: got %h expected no entry", trace_entry);
            end else begin
                chk("trace_entry", trace_entry, exp_q.pop_front());
            end
        end
    end

    // One bus transaction: valid for cycles 0..delay with ready at cycle delay,
    // optional address change at cycle chg_at, optional valid drop at cycle drop_at.
    task automatic txn(input bit wr, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] rd, input logic [3:0] s, input bit er,
                       input int delay, input int chg_at, input int drop_at, input bit pop);
        bit done;
        done = 0;
        req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d;
        req_wstrb = s; rsp_rdata = rd; rsp_error = er;
        for (int c = 0; c <= delay && !done; c++) begin
            if (c == drop_at) begin
                req_valid = 1'b0;
                rsp_ready = 1'b0;
                done = 1;
            end else begin
                if (c == chg_at) req_addr = a ^ 32'h0000_0004;
                rsp_ready = (c == delay);
                trace_pop = pop && (c == delay);
            end
            @(posedge clk); #1;
        end
        req_valid = 1'b0; rsp_ready = 1'b0; trace_pop = 1'b0; rsp_error = 1'b0;
        if (m_en) begin
            if (drop_at >= 0) begin
                m_proto = 1;
            end else begin
                if (wr) m_wr++; else m_rd++;
                if (er) m_err++;
                if (delay >= TMO) begin
                    m_tmo = 1;
                    mpush(mk(1'b1, 1'b0, wr, s, a, 32'h0, TMO));
                end else begin
                    mpush(mk(1'b0, er, wr, s, a, wr ? d : rd, delay));
                end
                if (chg_at >= 1 && chg_at < delay) m_proto = 1;
            end
        end
    endtask

    task automatic rand_txn(input int max_delay);
        txn(1'($urandom_range(0, 1)), $urandom, $urandom, $urandom, 4'($urandom_range(0, 15)),
            ($urandom_range(0, 3) == 0), $urandom_range(0, max_delay), -1, -1, 1'b0);
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_count"}, trace_count, exp_q.size());
        chk({tag, "_overflow"}, overflow, m_ovf);
        chk({tag, "_timeout"}, timeout, m_tmo);
        chk({tag, "_proto"}, proto_err, m_proto);
        chk({tag, "_rd"}, rd_count, m_rd);
        chk({tag, "_wr"}, wr_count, m_wr);
        chk({tag, "_err"}, err_count, m_err);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_valid"}, trace_valid, 1'b0);
        chk({tag, "_entry"}, trace_entry, '0);
        check_state(tag);
    endtask

    task automatic drain();
        trace_pop = 1'b1;
        for (int i = 0; i < 40 && trace_valid; i++) begin
            @(posedge clk); #1;
        end
        trace_pop = 1'b0;
        chk("drain_dut_empty", trace_valid, 1'b0);
        chk("drain_model_empty", exp_q.size(), 0);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        model_clear();
    endtask

    initial begin
        model_clear();
        m_en = 0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 1'b0; enable = 1'b1; m_en = 1;
        @(posedge clk); #1;

        txn(1'b0, 32'h10, 32'h0, 32'hCAFE, 4'h0, 1'b0, 0, -1, -1, 1'b0);
        chk("read_rd_count", rd_count, 32'd1);
        txn(1'b1, 32'h20, 32'h55, 32'hDEAD, 4'hF, 1'b0, 3, -1, -1, 1'b0);
        chk("write_wr_count", wr_count, 32'd1);
        check_state("directed");
        drain();

        for (int i = 0; i < 12; i++) rand_txn(6);
        check_state("random");
        drain();

        txn(1'b1, 32'h40, 32'h1234, 32'h0, 4'h3, 1'b0, TMO - 1, -1, -1, 1'b0);
        chk("no_timeout_at_255", timeout, 1'b0);
        txn(1'b0, 32'h44, 32'h0, 32'hBEEF, 4'h0, 1'b1, TMO + 4, -1, -1, 1'b0);
        check_state("timeout");
        do_clear();
        check_zero("clear");

        txn(1'b1, 32'h80, 32'h77, 32'h0, 4'h5, 1'b0, 4, 2, -1, 1'b0);
        check_state("addr_change");
        drain();
        do_clear();
        txn(1'b0, 32'h90, 32'h0, 32'h11, 4'h0, 1'b0, 5, -1, 3, 1'b0);
        check_state("valid_drop");

        do_clear();
        for (int i = 0; i < DEPTH + 1; i++) rand_txn(2);
        check_state("overflow");
        drain();

        do_clear();
        for (int i = 0; i < DEPTH; i++) rand_txn(1);
        check_state("full");
        txn(1'b1, 32'hA0, 32'hA5A5, 32'h0, 4'hC, 1'b0, 0, -1, -1, 1'b1);
        check_state("push_pop_full");

        enable = 1'b0; m_en = 0;
        for (int i = 0; i < 3; i++) rand_txn(3);
        enable = 1'b1; m_en = 1;
        check_state("disabled");
        drain();

        req_valid = 1'b1; req_addr = 32'hC0; rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        model_clear();
        check_zero("rst_mid");
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check_state("after_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

endmodule
